gen_scheduler: RTL and testbench
================================

// Module: gen_scheduler
// PURPOSE
//  Sequencer/arbiter for the shared row register file of the CGoL engine.
//  Shares the single row-address port between three users: the external
//  pattern loader, the next-generation compute sweep and the display scan.
//  Sits between the user controls and the prev/current row stores and the
//  display controller; replaces the free-running read/write toggle.
// PARAMETERS
//  WIDTH     8   board width in cells (row data width; pass-through only)
//  REGBITS   3   row address bits; board has NROWS = 2**REGBITS rows
//  DISP_HOLD 4   cycles each row is held on the display scan (>=1)
// PORTS
//  ph1         in   1        single system clock, rising edge
//  reset       in   1        async reset, active-low (0 = reset asserted)
//  run         in   1        level: compute generations continuously
//  step        in   1        level/pulse: compute one generation when idle
//  load_req    in   1        request to write one pattern row
//  load_addr   in   REGBITS  row address for load
//  load_ack    out  1        1-cycle pulse: load row written this cycle
//  rf_addr     out  REGBITS  row address to the register file
//  rf_we       out  1        write strobe to the row store
//  upd_commit  out  1        1-cycle pulse: copy current state to previous
//  disp_row    out  REGBITS  row currently driven on the display
//  disp_en     out  1        display scan active (rf_addr = disp_row)
//  busy        out  1        1 in LOAD, COMPUTE, COMMIT
//  gen_count   out  16       completed generations, wraps 0xFFFF -> 0
// BEHAVIOUR
//  - All outputs are Moore-decoded from registered state/counters.
//  - Reset (async, reset=0): state=IDLE, row_cnt=0, hold_cnt=0, disp_row=0,
//    gen_count=0; so rf_we=0, load_ack=0, upd_commit=0, busy=0, disp_en=1,
//    rf_addr=0. Reset mid-sweep aborts the sweep; no commit pulse follows.
//  - States: IDLE, LOAD, COMPUTE, COMMIT, DISPLAY.
//  - IDLE: disp_en=1, rf_addr=disp_row. Priority: load_req > (run|step).
//    load_req -> LOAD; else run|step -> COMPUTE with row_cnt=0.
//  - LOAD (1 cycle): rf_addr=load_addr, rf_we=1, load_ack=1 -> IDLE.
//  - COMPUTE: rf_addr=row_cnt, rf_we=1 every cycle; row_cnt increments;
//    at row_cnt=NROWS-1 -> COMMIT (row_cnt wraps to 0). NROWS cycles.
//  - COMMIT (1 cycle): upd_commit=1, rf_we=0, gen_count+=1 -> DISPLAY.
//  - DISPLAY: disp_en=1; scans one full frame (NROWS*DISP_HOLD cycles),
//    then -> COMPUTE if run=1, else -> IDLE.
//  - Display scan: in IDLE and DISPLAY, hold_cnt counts 0..DISP_HOLD-1; on
//    wrap disp_row increments, NROWS-1 wraps to 0. Counters freeze (hold
//    value) in LOAD/COMPUTE/COMMIT; disp_en=0 there. DISPLAY entry resets
//    disp_row=0, hold_cnt=0.
//  - Latency (defaults): step sampled in IDLE -> COMPUTE next edge; IDLE
//    re-entered 8+1+32 = 41 cycles after COMPUTE entry.
//  - load_req or step outside IDLE: ignored, not queued (load_req must be held
//    until load_ack). run dropped mid-generation: generation and its
//    DISPLAY frame complete, then IDLE.
//  - step held high acts like run (one generation per IDLE visit).
// CONFIGURATION
//  GEN_LIMIT_EN defined: adds input gen_limit[15:0] and output limit_hit.
//    On the COMMIT making gen_count == gen_limit, limit_hit is set (sticky);
//    DISPLAY then -> IDLE regardless of run; while limit_hit=1, run is
//    ignored, step still works. limit_hit clears on reset or LOAD.
//    gen_limit=0 disables the limit.
//  Not defined: no extra ports; run continues indefinitely.
// TESTING
//  - Reset: reset=0 mid-COMPUTE at row 5 -> next cycle state IDLE, rf_we=0,
//    gen_count=0, disp_row=0, disp_en=1; no upd_commit pulse ever seen.
//  - Load: load_req=1, load_addr=3 in IDLE -> 1 cycle later rf_addr=3,
//    rf_we=1, load_ack=1; back in IDLE next cycle.
//  - Step: single step pulse -> rf_we high 8 cycles with rf_addr 0..7,
//    then upd_commit 1 cycle, gen_count=1, 32 DISPLAY cycles, IDLE.
//  - Run: run=1 for 3 generations -> gen_count=3, COMPUTE re-entered directly
//    from DISPLAY each time; drop run -> IDLE after current frame.
//  - Conflict: load_req+step together in IDLE -> LOAD first, COMPUTE next;
//    load_req during COMPUTE -> no load_ack until IDLE.
//  - GEN_LIMIT_EN: gen_limit=2, run=1 -> limit_hit after 2nd commit,
//    IDLE after frame, gen_count stays 2 with run still 1.

Source files
------------

// File: rtl/gen_scheduler.sv
// gen_scheduler: shares the row-address port between pattern load, generation sweep and display scan.
// Define GEN_LIMIT_EN to add gen_limit/limit_hit, which stop continuous run after a set generation count.
module gen_scheduler #(
    parameter int WIDTH     = 8,
    parameter int REGBITS   = 3,
    parameter int DISP_HOLD = 4
) (
    input  logic               ph1,
    input  logic               reset,
    input  logic               run,
    input  logic               step,
    input  logic               load_req,
    input  logic [REGBITS-1:0] load_addr,
    output logic               load_ack,
    output logic [REGBITS-1:0] rf_addr,
    output logic               rf_we,
    output logic               upd_commit,
    output logic [REGBITS-1:0] disp_row,
    output logic               disp_en,
    output logic               busy,
    output logic [15:0]        gen_count
`ifdef GEN_LIMIT_EN
    ,
    input  logic [15:0]        gen_limit,
    output logic               limit_hit
`endif
);
    localparam int HB = DISP_HOLD > 1 ? $clog2(DISP_HOLD) : 1;
    typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, COMMIT, DISPLAY} state_t;
    state_t             state;
    logic [REGBITS-1:0] row_cnt, load_row;
    logic [HB-1:0]      hold_cnt;
    logic               scan, hold_wrap, frame_end, run_ok;
    if (WIDTH < 1 || DISP_HOLD < 1) begin : g_bad_param
        $error("gen_scheduler: WIDTH and DISP_HOLD must be >= 1");
    end
`ifdef GEN_LIMIT_EN
    assign run_ok = run && !limit_hit;
`else
    assign run_ok = run;
`endif
    assign scan       = state == IDLE || state == DISPLAY;
    assign hold_wrap  = hold_cnt == HB'(DISP_HOLD - 1);
    assign frame_end  = state == DISPLAY && hold_wrap && disp_row == '1;
    assign load_ack   = state == LOAD;
    assign rf_we      = state == LOAD || state == COMPUTE;
    assign upd_commit = state == COMMIT;
    assign disp_en    = scan;
    assign busy       = !scan;
    assign rf_addr    = state == LOAD ? load_row : state == COMPUTE ? row_cnt : disp_row;
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            row_cnt   <= '0;
            load_row  <= '0;
            hold_cnt  <= '0;
            disp_row  <= '0;
            gen_count <= '0;
`ifdef GEN_LIMIT_EN
            limit_hit <= 1'b0;
`endif
        end else begin
            if (scan) begin
                hold_cnt <= hold_wrap ? '0 : hold_cnt + 1'b1;
                if (hold_wrap) disp_row <= disp_row + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (load_req) begin
                        state    <= LOAD;
                        load_row <= load_addr;
                    end else if (run_ok || step) begin
                        state   <= COMPUTE;
                        row_cnt <= '0;
                    end
                end
                LOAD: begin
                    state <= IDLE;
`ifdef GEN_LIMIT_EN
                    limit_hit <= 1'b0;
`endif
                end
                COMPUTE: begin
                    row_cnt <= row_cnt + 1'b1;
                    if (row_cnt == '1) state <= COMMIT;
                end
                COMMIT: begin
                    // the new frame always starts from row 0, whatever the idle scan reached
                    state     <= DISPLAY;
                    gen_count <= gen_count + 16'd1;
                    hold_cnt  <= '0;
                    disp_row  <= '0;
`ifdef GEN_LIMIT_EN
                    if (gen_limit != 16'd0 && gen_count + 16'd1 == gen_limit) limit_hit <= 1'b1;
`endif
                end
                DISPLAY: if (frame_end) state <= run_ok ? COMPUTE : IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gen_scheduler.sv
// tb_gen_scheduler: directed vector table plus multi-cycle sequences for gen_scheduler (defaults 8/3/4).
module tb_gen_scheduler;
    logic        ph1 = 1'b0, reset = 1'b0, run = 1'b0, step = 1'b0, load_req = 1'b0;
    logic [2:0]  load_addr = 3'd0;
    logic        load_ack, rf_we, upd_commit, disp_en, busy;
    logic [2:0]  rf_addr, disp_row;
    logic [15:0] gen_count;
`ifdef GEN_LIMIT_EN
    logic [15:0] gen_limit = 16'd0;
    logic        limit_hit;
`endif
    int checks = 0, errors = 0;

    gen_scheduler #(.WIDTH(8), .REGBITS(3), .DISP_HOLD(4)) dut (
        .ph1(ph1), .reset(reset), .run(run), .step(step),
        .load_req(load_req), .load_addr(load_addr), .load_ack(load_ack),
        .rf_addr(rf_addr), .rf_we(rf_we), .upd_commit(upd_commit),
        .disp_row(disp_row), .disp_en(disp_en), .busy(busy), .gen_count(gen_count)
`ifdef GEN_LIMIT_EN
        , .gen_limit(gen_limit), .limit_hit(limit_hit)
`endif
    );

    always #5 ph1 = ~ph1;

    typedef struct packed {
        logic       run, step, load_req;
        logic [2:0] load_addr;
        logic       we, ack, cm, en, bsy;
        logic [2:0] addr, drow;
    } vec_t;
    vec_t vecs [9];

    task automatic tick();
        @(posedge ph1);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // entered on the first DISPLAY cycle; leaves on the last one
    task automatic display_frame(input int g);
        for (int k = 0; k < 32; k++) begin
            if (k > 0) tick();
            chk($sformatf("g%0d_disp_en_%0d", g, k), int'(disp_en), 1);
            chk($sformatf("g%0d_disp_busy_%0d", g, k), int'(busy), 0);
            chk($sformatf("g%0d_disp_row_%0d", g, k), int'(disp_row), k / 4);
            chk($sformatf("g%0d_disp_addr_%0d", g, k), int'(rf_addr), k / 4);
            chk($sformatf("g%0d_disp_we_%0d", g, k), int'(rf_we | upd_commit | load_ack), 0);
            chk($sformatf("g%0d_disp_gen_%0d", g, k), int'(gen_count), g);
        end
    endtask

    // entered on the first COMPUTE cycle
    task automatic compute_gen(input int g);
        for (int r = 0; r < 8; r++) begin
            chk($sformatf("g%0d_row_addr_%0d", g, r), int'(rf_addr), r);
            chk($sformatf("g%0d_row_we_%0d", g, r), int'(rf_we), 1);
            chk($sformatf("g%0d_row_busy_%0d", g, r), int'(busy), 1);
            chk($sformatf("g%0d_row_en_%0d", g, r), int'(disp_en), 0);
            chk($sformatf("g%0d_row_ack_%0d", g, r), int'(load_ack | upd_commit), 0);
            tick();
        end
        chk($sformatf("g%0d_commit", g), int'(upd_commit), 1);
        chk($sformatf("g%0d_commit_we", g), int'(rf_we), 0);
        chk($sformatf("g%0d_commit_busy", g), int'(busy), 1);
        chk($sformatf("g%0d_commit_gen", g), int'(gen_count), g - 1);
        tick();
        display_frame(g);
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 3'd1};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 3'd1};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 3'd1};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd6, 3'd1};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 3'd1};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd1};
        #12;
        chk("rst_we", int'(rf_we), 0);
        chk("rst_ack", int'(load_ack), 0);
        chk("rst_commit", int'(upd_commit), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_disp_en", int'(disp_en), 1);
        chk("rst_addr", int'(rf_addr), 0);
        chk("rst_disp_row", int'(disp_row), 0);
        chk("rst_gen", int'(gen_count), 0);
`ifdef GEN_LIMIT_EN
        chk("rst_limit_hit", int'(limit_hit), 0);
`endif
        reset = 1'b1;
        for (int i = 0; i < 9; i++) begin
            run = vecs[i].run;
            step = vecs[i].step;
            load_req = vecs[i].load_req;
            load_addr = vecs[i].load_addr;
            tick();
            chk($sformatf("v%0d_we", i), int'(rf_we), int'(vecs[i].we));
            chk($sformatf("v%0d_ack", i), int'(load_ack), int'(vecs[i].ack));
            chk($sformatf("v%0d_commit", i), int'(upd_commit), int'(vecs[i].cm));
            chk($sformatf("v%0d_disp_en", i), int'(disp_en), int'(vecs[i].en));
            chk($sformatf("v%0d_busy", i), int'(busy), int'(vecs[i].bsy));
            chk($sformatf("v%0d_disp_row", i), int'(disp_row), int'(vecs[i].drow));
            if (vecs[i].en || vecs[i].we) chk($sformatf("v%0d_addr", i), int'(rf_addr), int'(vecs[i].addr));
        end
        step = 1'b0;
        compute_gen(1);
        step = 1'b1;
        tick();
        chk("frame_end_idle_busy", int'(busy), 0);
        chk("frame_end_idle_gen", int'(gen_count), 1);
        tick();
        chk("step_from_idle_we", int'(rf_we), 1);
        chk("step_from_idle_addr", int'(rf_addr), 0);
        step = 1'b0;
        run = 1'b1;
        compute_gen(2);
        tick();
        chk("run_direct2_we", int'(rf_we), 1);
        chk("run_direct2_addr", int'(rf_addr), 0);
        compute_gen(3);
        tick();
        chk("run_direct3_we", int'(rf_we), 1);
        chk("run_gen3", int'(gen_count), 3);
        run = 1'b0;
        load_req = 1'b1;
        load_addr = 3'd5;
        compute_gen(4);
        tick();
        chk("run_drop_idle_busy", int'(busy), 0);
        chk("run_drop_idle_ack", int'(load_ack), 0);
        tick();
        chk("late_load_ack", int'(load_ack), 1);
        chk("late_load_addr", int'(rf_addr), 5);
        chk("late_load_we", int'(rf_we), 1);
        load_req = 1'b0;
        tick();
        chk("late_load_idle", int'(busy), 0);
        chk("late_load_gen", int'(gen_count), 4);
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (5) tick();
        chk("pre_reset_row", int'(rf_addr), 5);
        #2 reset = 1'b0;
        #1;
        chk("mid_reset_we", int'(rf_we), 0);
        chk("mid_reset_busy", int'(busy), 0);
        chk("mid_reset_gen", int'(gen_count), 0);
        chk("mid_reset_disp_row", int'(disp_row), 0);
        chk("mid_reset_disp_en", int'(disp_en), 1);
        #2 reset = 1'b1;
        begin
            logic seen_commit, seen_busy;
            seen_commit = 1'b0;
            seen_busy = 1'b0;
            for (int c = 0; c < 50; c++) begin
                tick();
                seen_commit |= upd_commit;
                seen_busy |= busy;
            end
            chk("post_reset_no_commit", int'(seen_commit), 0);
            chk("post_reset_stays_idle", int'(seen_busy), 0);
        end
`ifdef GEN_LIMIT_EN
        gen_limit = 16'd2;
        run = 1'b1;
        tick();
        chk("limit_start", int'(limit_hit), 0);
        compute_gen(1);
        tick();
        chk("limit_not_yet", int'(limit_hit), 0);
        compute_gen(2);
        chk("limit_hit_set", int'(limit_hit), 1);
        tick();
        chk("limit_idle_busy", int'(busy), 0);
        repeat (3) tick();
        chk("limit_hold_busy", int'(busy), 0);
        chk("limit_hold_gen", int'(gen_count), 2);
        run = 1'b0;
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        tick();
        chk("limit_cleared_by_load", int'(limit_hit), 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
